// File: rtl/mfm_pkg.sv
// Shared types, constants and helpers for the MFM write path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mfm_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } mfm_state_e;

    localparam logic [7:0]  MFM_FILLER_BYTE = 8'h4E;
    localparam logic [15:0] CRC_POLY        = 16'h1021;
    localparam logic [15:0] CRC_INIT        = 16'hFFFF;

    // MSB-first MFM: each data bit becomes {clock, data}; a clock cell is
    // written only between two zero data bits. Result bit 15 is sent first.
    function automatic logic [15:0] mfm_encode_byte(input logic [7:0] data, input logic prev);
        logic [15:0] cells;
        logic        p;
        cells = '0;
        p     = prev;
        for (int i = 7; i >= 0; i--) begin
            cells[2*i+1] = ~p & ~data[i];
            cells[2*i]   = data[i];
            p            = data[i];
        end
        return cells;
    endfunction

    // One byte of CRC-16-CCITT, MSB first.
    function automatic logic [15:0] crc_fold(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/mfm_cell_timer.sv
// Cell timing for the MFM writer: cell cycle counter, write-pulse generator, last-cycle strobe.
// Latency: pulse output is registered, aligned with the first cycle of the cell it belongs to.
// Backpressure: none; free-runs while run is high, holds at zero otherwise.
//
// Ports: clk/rst (sync, active-high); run = writer currently shifting;
// run_nxt/cell_bit_nxt = shifting state and cell bit of the coming cycle;
// cell_last = final cycle of the current cell; pulse = write-data pulse.
module mfm_cell_timer #(
    parameter int CELL_CLKS  = 16,
    parameter int PULSE_CLKS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic run_nxt,
    input  logic cell_bit_nxt,
    output logic cell_last,
    output logic pulse
);

    localparam int            CW        = (CELL_CLKS > 1) ? $clog2(CELL_CLKS) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(CELL_CLKS - 1);
    localparam logic [CW-1:0] PULSE_LIM = CW'(PULSE_CLKS);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          pulse_q, pulse_d;

    assign cell_last = run && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = '0;
        if (run && !cell_last) begin
            cnt_d = cnt_q + CW'(1);
        end
        // Pulse is decided one cycle ahead so the output can be a flop.
        pulse_d = run_nxt && cell_bit_nxt && (cnt_d < PULSE_LIM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/mfm_write_encoder.sv
// MFM write encoder: byte stream in, floppy write-pulse train and write gate out.
// Latency: gate and first cell pulse appear the cycle after acceptance; words run back-to-back.
// Backpressure: DATA_READY only in IDLE or the last cycle of a word; no buffering, underrun sends 8'h4E.
//
// Ports: CLK, RESET (sync active-high); WRITE_EN session request; DATA_IN/DATA_SYNC_IN/
// DATA_VALID/DATA_READY byte handshake; SYNC_WORD_IN raw cells for sync entries;
// FD_WRDATA_OUT pulse, FD_WRGATE_OUT gate, BUSY, UNDERRUN (sticky per session).
// Optional macro MFM_WRITE_CRC_EN adds DATA_CRC_IN, CRC_OUT and the SYNC_DATA_BYTE parameter.
module mfm_write_encoder
    import mfm_pkg::*;
#(
    parameter int CELL_CLKS  = 16,
    parameter int PULSE_CLKS = 4
`ifdef MFM_WRITE_CRC_EN
    ,
    parameter logic [7:0] SYNC_DATA_BYTE = 8'hA1
`endif
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        WRITE_EN,
    input  logic [7:0]  DATA_IN,
    input  logic        DATA_SYNC_IN,
    input  logic        DATA_VALID,
    output logic        DATA_READY,
    input  logic [15:0] SYNC_WORD_IN,
`ifdef MFM_WRITE_CRC_EN
    input  logic        DATA_CRC_IN,
    output logic [15:0] CRC_OUT,
`endif
    output logic        FD_WRDATA_OUT,
    output logic        FD_WRGATE_OUT,
    output logic        BUSY,
    output logic        UNDERRUN
);

    mfm_state_e  state_q, state_d;
    logic [15:0] shift_q, shift_d;
    logic [3:0]  idx_q, idx_d;
    logic        prev_q, prev_d;
    logic        gate_q, gate_d;
    logic        underrun_q, underrun_d;
    logic        cell_last, cell_bit_nxt, accept, load;
    logic [15:0] entry_word, load_word;
`ifdef MFM_WRITE_CRC_EN
    logic [15:0] crc_q, crc_d;
    logic [7:0]  crc_lo_q, crc_lo_d;
    logic        crc_pend_q, crc_pend_d;
    logic        last_sync_q, last_sync_d;
    logic        crc_hold;
    assign crc_hold = crc_pend_q;
`else
    logic        crc_hold;
    assign crc_hold = 1'b0;
`endif

    // Ready only while idle or on the final cycle of cell 0; the low CRC
    // byte owns the next boundary when pending.
    assign DATA_READY = !RESET && WRITE_EN && !crc_hold &&
                        ((state_q == ST_IDLE) || (cell_last && (idx_q == 4'd0)));
    assign accept     = DATA_READY && DATA_VALID;

    always_comb begin
        entry_word = DATA_SYNC_IN ? SYNC_WORD_IN : mfm_encode_byte(DATA_IN, prev_q);
`ifdef MFM_WRITE_CRC_EN
        crc_d       = crc_q;
        crc_lo_d    = crc_lo_q;
        crc_pend_d  = crc_pend_q;
        last_sync_d = last_sync_q;
        if (DATA_CRC_IN) begin
            entry_word = mfm_encode_byte(crc_q[15:8], prev_q);
        end
`endif
        state_d    = state_q;
        shift_d    = shift_q;
        idx_d      = idx_q;
        prev_d     = prev_q;
        underrun_d = underrun_q;
        load       = 1'b0;
        load_word  = entry_word;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d    = ST_SHIFT;
                    underrun_d = 1'b0;
                    load       = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (cell_last) begin
                    if (idx_q != 4'd0) begin
                        idx_d = idx_q - 4'd1;
                    end else if (accept) begin
                        load = 1'b1;
`ifdef MFM_WRITE_CRC_EN
                    end else if (crc_pend_q) begin
                        load       = 1'b1;
                        load_word  = mfm_encode_byte(crc_lo_q, prev_q);
                        crc_pend_d = 1'b0;
`endif
                    end else if (WRITE_EN) begin
                        load       = 1'b1;
                        load_word  = mfm_encode_byte(MFM_FILLER_BYTE, prev_q);
                        underrun_d = 1'b1;
`ifdef MFM_WRITE_CRC_EN
                        crc_d       = crc_fold(crc_q, MFM_FILLER_BYTE);
                        last_sync_d = 1'b0;
`endif
                    end else begin
                        // Session over; next session starts with prev = 0.
                        state_d = ST_IDLE;
                        prev_d  = 1'b0;
`ifdef MFM_WRITE_CRC_EN
                        last_sync_d = 1'b0;
`endif
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef MFM_WRITE_CRC_EN
        // CRC bytes themselves are not folded, so CRC_OUT stays stable
        // while the two trailing words go out.
        if (accept) begin
            if (DATA_CRC_IN) begin
                crc_lo_d    = crc_q[7:0];
                crc_pend_d  = 1'b1;
                last_sync_d = 1'b0;
            end else if (DATA_SYNC_IN) begin
                crc_d       = crc_fold(last_sync_q ? crc_q : CRC_INIT, SYNC_DATA_BYTE);
                last_sync_d = 1'b1;
            end else begin
                crc_d       = crc_fold(crc_q, DATA_IN);
                last_sync_d = 1'b0;
            end
        end
`endif

        // The last cell of any word is its final data bit (or the sync
        // word's LSB), which is exactly the prev for the next word.
        if (load) begin
            shift_d = load_word;
            idx_d   = 4'd15;
            prev_d  = load_word[0];
        end

        gate_d       = (state_d == ST_SHIFT);
        cell_bit_nxt = shift_d[idx_d];
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            idx_q      <= '0;
            prev_q     <= 1'b0;
            gate_q     <= 1'b0;
            underrun_q <= 1'b0;
`ifdef MFM_WRITE_CRC_EN
            crc_q       <= '0;
            crc_lo_q    <= '0;
            crc_pend_q  <= 1'b0;
            last_sync_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            idx_q      <= idx_d;
            prev_q     <= prev_d;
            gate_q     <= gate_d;
            underrun_q <= underrun_d;
`ifdef MFM_WRITE_CRC_EN
            crc_q       <= crc_d;
            crc_lo_q    <= crc_lo_d;
            crc_pend_q  <= crc_pend_d;
            last_sync_q <= last_sync_d;
`endif
        end
    end

    mfm_cell_timer #(
        .CELL_CLKS (CELL_CLKS),
        .PULSE_CLKS(PULSE_CLKS)
    ) u_cell_timer (
        .clk         (CLK),
        .rst         (RESET),
        .run         (state_q == ST_SHIFT),
        .run_nxt     (gate_d),
        .cell_bit_nxt(cell_bit_nxt),
        .cell_last   (cell_last),
        .pulse       (FD_WRDATA_OUT)
    );

    assign FD_WRGATE_OUT = gate_q;
    assign BUSY          = gate_q;
    assign UNDERRUN      = underrun_q;
`ifdef MFM_WRITE_CRC_EN
    assign CRC_OUT       = crc_q;
`endif

endmodule

// File: tb/tb_mfm_write_encoder.sv
// Testbench for mfm_write_encoder (default build, CRC option off).
// Scoreboard of expected 16-cell words fed by the driver, drained by a pulse-train monitor.
// Reference encoder works on data/clock cell pairs with plain arithmetic.
module tb_mfm_write_encoder;

    localparam int CELL  = 16;
    localparam int PULSE = 4;
    localparam int WORD_CLKS = 16 * CELL;

    logic        CLK, RESET, WRITE_EN, DATA_SYNC_IN, DATA_VALID, DATA_READY;
    logic [7:0]  DATA_IN;
    logic [15:0] SYNC_WORD_IN;
    logic        FD_WRDATA_OUT, FD_WRGATE_OUT, BUSY, UNDERRUN;

    mfm_write_encoder #(.CELL_CLKS(CELL), .PULSE_CLKS(PULSE)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .WRITE_EN     (WRITE_EN),
        .DATA_IN      (DATA_IN),
        .DATA_SYNC_IN (DATA_SYNC_IN),
        .DATA_VALID   (DATA_VALID),
        .DATA_READY   (DATA_READY),
        .SYNC_WORD_IN (SYNC_WORD_IN),
        .FD_WRDATA_OUT(FD_WRDATA_OUT),
        .FD_WRGATE_OUT(FD_WRGATE_OUT),
        .BUSY         (BUSY),
        .UNDERRUN     (UNDERRUN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_load = 0;
    bit          m_prev = 1'b0;
    logic [15:0] exp_q[$];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Each data bit d becomes a 2-cell pair: d=1 -> 01, d=0 -> 10 after a 0, 00 after a 1.
    function automatic logic [15:0] model_encode(input logic [7:0] b, input bit p);
        int w;
        int d;
        bit pr;
        w  = 0;
        pr = p;
        for (int i = 7; i >= 0; i--) begin
            d  = (int'(b) >> i) & 1;
            w  = w * 4 + ((d == 1) ? 1 : (pr ? 0 : 2));
            pr = (d == 1);
        end
        return w[15:0];
    endfunction

    // ---------------- monitor ----------------
    int          mon_pos = 0;
    int          shape_bad = 0;
    bit          mon_bit = 1'b0;
    logic [15:0] mon_word = '0;
    logic [15:0] exp_w;

    always @(negedge CLK) begin
        if (FD_WRGATE_OUT !== BUSY) shape_bad++;
        if (FD_WRGATE_OUT !== 1'b1) begin
            mon_pos  = 0;
            mon_word = '0;
            if (FD_WRDATA_OUT !== 1'b0) shape_bad++;
        end else begin
            if ((mon_pos % CELL) == 0) begin
                mon_bit  = (FD_WRDATA_OUT === 1'b1);
                mon_word = {mon_word[14:0], mon_bit};
            end else if (FD_WRDATA_OUT !== (mon_bit && ((mon_pos % CELL) < PULSE))) begin
                shape_bad++;
            end
            mon_pos++;
            if (mon_pos == WORD_CLKS) begin
                mon_pos = 0;
                chk("scoreboard_has_entry", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    exp_w = exp_q.pop_front();
                    chk("word_cells", mon_word, exp_w);
                end
                chk("pulse_shape", shape_bad, 0);
                shape_bad = 0;
            end
        end
    end

    // ---------------- driver ----------------
    // Tasks are entered 1 time unit after a rising edge.
    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (DATA_READY === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(posedge CLK);
            #2;
        end
    endtask

    task automatic send(input logic [7:0] b, input bit sync, input logic [15:0] sw, input bit first);
        logic [15:0] w;
        bit ok;
        DATA_IN      = b;
        DATA_SYNC_IN = sync;
        SYNC_WORD_IN = sync ? sw : 16'($urandom);
        DATA_VALID   = 1'b1;
        #1;
        wait_ready(ok);
        chk("ready_seen", ok, 1);
        if (!ok) begin
            DATA_VALID = 1'b0;
            return;
        end
        w      = sync ? sw : model_encode(b, m_prev);
        m_prev = sync ? sw[0] : b[0];
        @(posedge CLK);
        #1;
        last_load = cyc;
        exp_q.push_back(w);
        DATA_VALID   = 1'b0;
        DATA_IN      = 8'($urandom);
        DATA_SYNC_IN = 1'($urandom);
        chk("gate_after_accept", FD_WRGATE_OUT, 1);
        chk("first_cell_pulse", FD_WRDATA_OUT, w[15]);
        if (first) chk("underrun_cleared_at_start", UNDERRUN, 0);
    endtask

    task automatic underrun_step();
        logic [15:0] w;
        bit ok;
        DATA_VALID = 1'b0;
        #1;
        wait_ready(ok);
        chk("boundary_seen", ok, 1);
        if (!ok) return;
        w      = model_encode(8'h4E, m_prev);
        m_prev = 1'b0;
        @(posedge CLK);
        #1;
        last_load = cyc;
        exp_q.push_back(w);
        chk("underrun_set", UNDERRUN, 1);
        chk("gate_held_on_underrun", FD_WRGATE_OUT, 1);
        chk("filler_first_pulse", FD_WRDATA_OUT, w[15]);
    endtask

    task automatic start_session();
        WRITE_EN = 1'b1;
        m_prev   = 1'b0;
    endtask

    task automatic end_session();
        bit done;
        done       = 1'b0;
        WRITE_EN   = 1'b0;
        DATA_VALID = 1'b0;
        for (int n = 0; n < 600; n++) begin
            @(posedge CLK);
            #1;
            if (FD_WRGATE_OUT === 1'b0) begin
                done = 1'b1;
                break;
            end
        end
        chk("gate_drop_seen", done, 1);
        if (done) chk("gate_drop_delay", cyc - last_load, WORD_CLKS);
        chk("busy_low_after_session", BUSY, 0);
    endtask

    initial begin
        int n_ent;
        int r;
        RESET        = 1'b1;
        WRITE_EN     = 1'b0;
        DATA_IN      = '0;
        DATA_SYNC_IN = 1'b0;
        DATA_VALID   = 1'b0;
        SYNC_WORD_IN = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_wrdata", FD_WRDATA_OUT, 0);
        chk("rst_gate", FD_WRGATE_OUT, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_underrun", UNDERRUN, 0);
        chk("rst_ready", DATA_READY, 0);
        RESET = 1'b0;

        // Valid without WRITE_EN is never accepted.
        DATA_VALID = 1'b1;
        DATA_IN    = 8'h55;
        repeat (20) @(posedge CLK);
        #1;
        chk("no_accept_without_en", FD_WRGATE_OUT, 0);
        DATA_VALID = 1'b0;

        // 00 from idle, then FF / 00 with prev carried.
        start_session();
        send(8'h00, 1'b0, 16'h0, 1'b1);
        end_session();
        start_session();
        send(8'hFF, 1'b0, 16'h0, 1'b1);
        send(8'h00, 1'b0, 16'h0, 1'b0);
        end_session();

        // Sync word, byte with carried prev, then an underrun filler.
        start_session();
        send(8'h00, 1'b1, 16'h4489, 1'b1);
        send(8'h4E, 1'b0, 16'h0, 1'b0);
        underrun_step();
        end_session();
        chk("underrun_sticky", UNDERRUN, 1);

        // Reset inside cell 7 of a word.
        start_session();
        send(8'hFF, 1'b0, 16'h0, 1'b1);
        repeat (8 * CELL + 3) @(posedge CLK);
        #1;
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        chk("midrst_wrdata", FD_WRDATA_OUT, 0);
        chk("midrst_gate", FD_WRGATE_OUT, 0);
        chk("midrst_busy", BUSY, 0);
        chk("midrst_underrun", UNDERRUN, 0);
        chk("midrst_ready", DATA_READY, 0);
        RESET    = 1'b0;
        WRITE_EN = 1'b0;
        exp_q.delete();
        @(posedge CLK);
        #1;
        start_session();
        send(8'h00, 1'b0, 16'h0, 1'b1);
        end_session();

        // Randomized sessions.
        for (int s = 0; s < 6; s++) begin
            repeat ($urandom_range(0, 5)) @(posedge CLK);
            #1;
            start_session();
            n_ent = $urandom_range(3, 7);
            for (int e = 0; e < n_ent; e++) begin
                r = $urandom_range(0, 7);
                if (r == 0 && e != 0) underrun_step();
                else if (r == 1) send(8'($urandom), 1'b1, 16'($urandom), e == 0);
                else send(8'($urandom), 1'b0, 16'h0, e == 0);
            end
            end_session();
        end

        repeat (5) @(posedge CLK);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("pulse_shape_final", shape_bad, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

endmodule
